// File: rtl/display_pkg.sv
// display_pkg: segment encoding shared by the scan controller and the hex decoder
// Segment word layout is {a,b,c,d,e,f,g,dp}, active-low.
package display_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'hFE;
  localparam int SEG_A = 7;
  localparam int SEG_B = 6;
  localparam int SEG_C = 5;
  localparam int SEG_D = 4;
  localparam int SEG_E = 3;
  localparam int SEG_F = 2;
  localparam int SEG_G = 1;
  localparam int SEG_DP = 0;
  localparam logic [15:0][7:0] SEG_TAB = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };
endpackage

// File: rtl/decod_hex7seg.sv
// decod_hex7seg: combinational hex nibble + decimal point to active-low segments
// Ports: nib (hex value), dp (1 = point lit), seg ({a..g,dp}, active-low).
module decod_hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = SEG_TAB[nib] & ~(8'(dp) << SEG_DP);
endmodule

// File: rtl/barrido_displays.sv
// barrido_displays: time-multiplexed 7-segment scan with guard interval and double-buffered value
// Ports: clk, rst_n (async, active-low), en (scan enable), load (capture strobe for valor/dp_in/blank),
//   valor (nibble i -> digit i, digit 0 rightmost), dp_in, blank, seg/an (active-low pins),
//   pend (load waiting for the frame boundary), tick_frame (high on the last cycle of the frame).
// Option: BLANK_CEROS_EN enables leading-zero suppression (digit 0 is never suppressed).
module barrido_displays
  import display_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int PRESC = 50000,
  parameter int GUARD = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [4*N_DIG-1:0] valor,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blank,
  output logic [7:0]         seg,
  output logic [N_DIG-1:0]   an,
  output logic               pend,
  output logic               tick_frame
);
  localparam int CW = $clog2(PRESC);
  localparam int IW = $clog2(N_DIG);
  localparam logic [CW-1:0] C_LAST = CW'(PRESC - 1);
  localparam logic [CW-1:0] C_PRE = CW'(PRESC - 2);
  localparam logic [CW-1:0] C_GRD = CW'(GUARD);
  localparam logic [IW-1:0] I_LAST = IW'(N_DIG - 1);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*N_DIG-1:0] pv, dv;
  logic [N_DIG-1:0] pdp, ddp, pbl, dbl, supp;
  logic [7:0] dec_seg;
  logic wrap, bnd, dark;
  assign wrap = en && cnt == C_LAST;
  assign bnd = wrap && idx == I_LAST;
  decod_hex7seg u_dec (
    .nib(dv[4*idx +: 4]),
    .dp (ddp[idx]),
    .seg(dec_seg)
  );
`ifdef BLANK_CEROS_EN
  logic z;
  // Walk down from the top digit: a digit is suppressed while every nibble at or above it is zero.
  always_comb begin
    z = 1'b1;
    supp = '0;
    for (int i = N_DIG - 1; i > 0; i--) begin
      z = z & (dv[4*i +: 4] == 4'h0);
      supp[i] = z;
    end
  end
`else
  assign supp = '0;
`endif
  // A suppressed zero with its point set still lights, showing only the point.
  assign dark = !en || cnt < C_GRD || dbl[idx] || (supp[idx] && !ddp[idx]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      pv <= '0;
      pdp <= '0;
      pbl <= '0;
      dv <= '0;
      ddp <= '0;
      dbl <= '0;
      pend <= 1'b0;
      seg <= SEG_OFF;
      an <= '1;
      tick_frame <= 1'b0;
    end else begin
      if (en) cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == I_LAST ? '0 : idx + 1'b1;
      if (load && bnd) begin
        dv <= valor;
        ddp <= dp_in;
        dbl <= blank;
        pend <= 1'b0;
      end else if (load) begin
        pv <= valor;
        pdp <= dp_in;
        pbl <= blank;
        pend <= 1'b1;
      end else if (bnd && pend) begin
        dv <= pv;
        ddp <= pdp;
        dbl <= pbl;
        pend <= 1'b0;
      end
      seg <= dark ? SEG_OFF : supp[idx] ? SEG_DP_ONLY : dec_seg;
      an <= dark ? '1 : ~(N_DIG'(1) << idx);
      // Decoded one cycle early so the registered pulse lines up with the boundary cycle itself.
      tick_frame <= en && cnt == C_PRE && idx == I_LAST;
    end
  end
endmodule

// File: tb/tb_barrido_displays.sv
// tb_barrido_displays: directed scoreboard bench for barrido_displays (N_DIG=4, PRESC=8, GUARD=2)
module tb_barrido_displays;
  localparam int N = 4;
  localparam int P = 8;
  localparam int G = 2;
  localparam logic [7:0] TAB [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [15:0] valor = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] blank = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic pend, tick_frame;
  int n_chk = 0;
  int n_fail = 0;
  logic [12:0] sb [$];

  barrido_displays #(.N_DIG(N), .PRESC(P), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .valor(valor), .dp_in(dp_in),
    .blank(blank), .seg(seg), .an(an), .pend(pend), .tick_frame(tick_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int p, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s p=%0d got %h expected %h", tag, p, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      hit = tick_frame === 1'b1;
    end
    check("sync_tick", 0, 8'(hit), 8'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    valor = v;
    dp_in = dp;
    blank = bl;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    int c, d;
    bit sup;
    logic [3:0] a;
    logic [7:0] s;
    for (int p = 0; p < 4 * P; p++) begin
      c = p % P;
      d = p / P;
      sup = 1'b0;
      a = 4'hF;
      s = 8'hFF;
`ifdef BLANK_CEROS_EN
      if (d > 0) begin
        sup = 1'b1;
        for (int j = d; j < N; j++) if (v[4*j +: 4] != 4'h0) sup = 1'b0;
      end
`endif
      if (c >= G && !bl[d] && !(sup && !dp[d])) begin
        a = ~(4'b0001 << d);
        s = sup ? 8'hFE : TAB[v[4*d +: 4]] & ~{7'b0, dp[d]};
      end
      sb.push_back({p == 4 * P - 2, a, s});
    end
  endtask

  task automatic scan_frame();
    logic [12:0] e;
    for (int p = 0; p < 4 * P; p++) begin
      step();
      e = sb.pop_front();
      check("an", p, 8'(an), 8'(e[11:8]));
      check("seg", p, seg, e[7:0]);
      check("tick", p, 8'(tick_frame), 8'(e[12]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check("rst_an", 0, 8'(an), 8'h0F);
    check("rst_seg", 0, seg, 8'hFF);
    check("rst_pend", 0, 8'(pend), 8'd0);
    check("rst_tick", 0, 8'(tick_frame), 8'd0);
    rst_n = 1'b1;
    en = 1'b1;
    push_frame(16'h0000, 4'b0000, 4'b0000);
    sync();
    step();
    scan_frame();
    do_load(16'h1230, 4'b0100, 4'b0000);
    check("load_pend", 0, 8'(pend), 8'd1);
    push_frame(16'h1230, 4'b0100, 4'b0000);
    sync();
    check("pend_hold", 0, 8'(pend), 8'd1);
    step();
    check("pend_clr", 0, 8'(pend), 8'd0);
    scan_frame();
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    step();
    step();
    step();
    do_load(16'hFFFF, 4'b0000, 4'b0000);
    check("pend_two", 0, 8'(pend), 8'd1);
    push_frame(16'hFFFF, 4'b0000, 4'b0000);
    sync();
    step();
    scan_frame();
    push_frame(16'h9C5E, 4'b0001, 4'b0000);
    sync();
    do_load(16'h9C5E, 4'b0001, 4'b0000);
    check("bypass_pend", 0, 8'(pend), 8'd0);
    scan_frame();
    check("bypass_pend_end", 0, 8'(pend), 8'd0);
    do_load(16'h1230, 4'b0000, 4'b0010);
    push_frame(16'h1230, 4'b0000, 4'b0010);
    sync();
    step();
    scan_frame();
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    step();
    check("dis_an", 0, 8'(an), 8'h0F);
    check("dis_seg", 0, seg, 8'hFF);
    for (int i = 0; i < 5; i++) step();
    check("dis_an_hold", 0, 8'(an), 8'h0F);
    check("dis_tick", 0, 8'(tick_frame), 8'd0);
    en = 1'b1;
    step();
    check("resume_an", 0, 8'(an), 8'h0E);
    check("resume_seg", 0, seg, 8'h03);
    for (int i = 0; i < 26; i++) begin
      step();
      check("resume_tick", i, 8'(tick_frame), 8'(i == 25));
    end
    step();
    do_load(16'h0012, 4'b0000, 4'b0000);
    push_frame(16'h0012, 4'b0000, 4'b0000);
    sync();
    step();
    scan_frame();
    do_load(16'h0012, 4'b1000, 4'b0000);
    push_frame(16'h0012, 4'b1000, 4'b0000);
    sync();
    step();
    scan_frame();
    do_load(16'h0000, 4'b0000, 4'b0000);
    push_frame(16'h0000, 4'b0000, 4'b0000);
    sync();
    step();
    scan_frame();
    do_load(16'h1230, 4'b0000, 4'b0000);
    step();
    step();
    step();
    check("pre_rst_an", 0, 8'(an), 8'h0E);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 0, 8'(an), 8'h0F);
    check("arst_seg", 0, seg, 8'hFF);
    check("arst_pend", 0, 8'(pend), 8'd0);
    check("arst_tick", 0, 8'(tick_frame), 8'd0);
    step();
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 4'b0000);
    sync();
    step();
    check("arst_pend_after", 0, 8'(pend), 8'd0);
    scan_frame();
    check("sb_empty", 0, 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
